// File: rtl/countdown_timer.sv
// Countdown timer: counts loadValue units (ms or us, derived from FREQ_IN) down to zero,
// with level pause, abort, restart on start, and a one-cycle done pulse at expiry.
module countdown_timer #(
    parameter int FREQ_IN         = 10000,
    parameter int SELECT_UNITS    = 0,
    parameter int SIZE_LOAD_TIMER = 10
) (
    input  logic                       clk,
    input  logic                       resetTimer,
    input  logic                       start,
    input  logic                       pause,
    input  logic                       abort,
    input  logic [SIZE_LOAD_TIMER-1:0] loadValue,
    output logic [SIZE_LOAD_TIMER-1:0] remainingTime,
    output logic                       busy,
    output logic                       done
);

    localparam int FREQ_OF_UNITS = (SELECT_UNITS == 0) ? 1000 : 1000000;
    localparam int UNIT_CYCLES   = FREQ_IN / FREQ_OF_UNITS;
    localparam int PRE_W         = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'((UNIT_CYCLES > 0) ? UNIT_CYCLES - 1 : 0);

    generate
        if (UNIT_CYCLES < 1) begin : g_bad_freq
            $error("countdown_timer: FREQ_IN is below one clock per time unit");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        DONE
    } state_t;

    state_t                     state     = IDLE;
    logic [PRE_W-1:0]           prescaler = '0;
    logic [SIZE_LOAD_TIMER-1:0] remaining = '0;
    logic                       busy_q    = 1'b0;
    logic                       done_q    = 1'b0;
    logic                       tick;

    assign tick          = (prescaler == PRE_LAST);
    assign remainingTime = remaining;
    assign busy          = busy_q;
    assign done          = done_q;

    // A cycle with pause low in PAUSED counts like a RUN cycle, so pause costs exactly its length.
    always_ff @(posedge clk or posedge resetTimer) begin
        if (resetTimer) begin
            state     <= IDLE;
            prescaler <= '0;
            remaining <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (abort) begin
            state     <= IDLE;
            prescaler <= '0;
            remaining <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (start) begin
            prescaler <= '0;
            if (loadValue == '0) begin
                state     <= DONE;
                remaining <= '0;
                busy_q    <= 1'b0;
                done_q    <= 1'b1;
            end else begin
                state     <= RUN;
                remaining <= loadValue;
                busy_q    <= 1'b1;
                done_q    <= 1'b0;
            end
        end else begin
            case (state)
                RUN, PAUSED: begin
                    if (pause) begin
                        state  <= PAUSED;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                    end else if (tick) begin
                        prescaler <= '0;
                        if (remaining <= SIZE_LOAD_TIMER'(1)) begin
                            state     <= DONE;
                            remaining <= '0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            state     <= RUN;
                            remaining <= remaining - SIZE_LOAD_TIMER'(1);
                            busy_q    <= 1'b1;
                            done_q    <= 1'b0;
                        end
                    end else begin
                        state     <= RUN;
                        prescaler <= prescaler + PRE_W'(1);
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench: a ms instance (10 cycles/unit) and a us instance (4 cycles/unit)
// share stimulus and are compared every cycle against an elapsed-cycle model.
module tb_countdown_timer;

    localparam int W = 10;

    logic         clk         = 1'b0;
    logic         reset_timer = 1'b1;
    logic         start       = 1'b0;
    logic         pause       = 1'b0;
    logic         abort       = 1'b0;
    logic [W-1:0] load_value  = '0;
    logic [1:0]   busy_w;
    logic [1:0]   done_w;
    logic [W-1:0] rem_w [2];

    int    unit_cycles [2] = '{10, 4};
    string dut_name    [2] = '{"ms", "us"};

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;
    int cyc      = 0;
    int done_at  [2] = '{-1, -1};

    bit m_active  [2] = '{1'b0, 1'b0};
    bit m_done    [2] = '{1'b0, 1'b0};
    int m_len     [2] = '{0, 0};
    int m_elapsed [2] = '{0, 0};

    countdown_timer #(.FREQ_IN(10000), .SELECT_UNITS(0), .SIZE_LOAD_TIMER(W)) dut_ms (
        .clk(clk), .resetTimer(reset_timer), .start(start), .pause(pause), .abort(abort),
        .loadValue(load_value), .remainingTime(rem_w[0]), .busy(busy_w[0]), .done(done_w[0])
    );

    countdown_timer #(.FREQ_IN(4000000), .SELECT_UNITS(1), .SIZE_LOAD_TIMER(W)) dut_us (
        .clk(clk), .resetTimer(reset_timer), .start(start), .pause(pause), .abort(abort),
        .loadValue(load_value), .remainingTime(rem_w[1]), .busy(busy_w[1]), .done(done_w[1])
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic s, input logic a, input logic p, input logic [W-1:0] l);
        start      = s;
        abort      = a;
        pause      = p;
        load_value = l;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            cyc++;
            for (int d = 0; d < 2; d++)
                if (done_at[d] < 0 && done_w[d] === 1'b1) done_at[d] = cyc;
        end
    endtask

    task automatic mark();
        cyc        = 0;
        done_at[0] = -1;
        done_at[1] = -1;
    endtask

    function automatic int exp_rem(input int d);
        return m_active[d] ? m_len[d] - m_elapsed[d] / unit_cycles[d] : 0;
    endfunction

    // Model: a countdown needs len*unit counted cycles; a cycle counts when pause is low.
    always @(posedge clk or posedge reset_timer) begin
        for (int d = 0; d < 2; d++) begin
            if (reset_timer) begin
                m_active[d]  = 1'b0;
                m_done[d]    = 1'b0;
                m_len[d]     = 0;
                m_elapsed[d] = 0;
            end else begin
                m_done[d] = 1'b0;
                if (abort) begin
                    m_active[d]  = 1'b0;
                    m_len[d]     = 0;
                    m_elapsed[d] = 0;
                end else if (start) begin
                    m_elapsed[d] = 0;
                    if (load_value == '0) begin
                        m_active[d] = 1'b0;
                        m_len[d]    = 0;
                        m_done[d]   = 1'b1;
                    end else begin
                        m_active[d] = 1'b1;
                        m_len[d]    = int'(load_value);
                    end
                end else if (m_active[d] && !pause) begin
                    m_elapsed[d]++;
                    if (m_elapsed[d] == m_len[d] * unit_cycles[d]) begin
                        m_active[d] = 1'b0;
                        m_done[d]   = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int d = 0; d < 2; d++) begin
                check_output({"busy_", dut_name[d]}, int'(busy_w[d]), int'(m_active[d]));
                check_output({"done_", dut_name[d]}, int'(done_w[d]), int'(m_done[d]));
                check_output({"rem_", dut_name[d]}, int'(rem_w[d]), exp_rem(d));
            end
        end
    end

    initial begin
        apply_stimulus(1'b0, 1'b0, 1'b0, '0);
        repeat (2) @(posedge clk);
        #2;
        reset_timer = 1'b0;
        cmp_en      = 1'b1;
        check_output("reset_busy", int'(busy_w[0]), 0);
        check_output("reset_done", int'(done_w[0]), 0);
        check_output("reset_rem", int'(rem_w[0]), 0);
        step(3);

        // Basic countdown of 3 units
        apply_stimulus(1'b1, 1'b0, 1'b0, 10'd3);
        step(1);
        mark();
        apply_stimulus(1'b0, 1'b0, 1'b0, 10'd3);
        check_output("basic_busy_rise", int'(busy_w[0]), 1);
        check_output("basic_rem_load", int'(rem_w[0]), 3);
        step(10);
        check_output("basic_rem_10", int'(rem_w[0]), 2);
        step(10);
        check_output("basic_rem_20", int'(rem_w[0]), 1);
        step(10);
        check_output("basic_done_latency_ms", done_at[0], 30);
        check_output("basic_done_latency_us", done_at[1], 12);
        check_output("basic_busy_at_done", int'(busy_w[0]), 0);
        check_output("basic_rem_at_done", int'(rem_w[0]), 0);
        step(1);
        check_output("basic_done_single", int'(done_w[0]), 0);
        step(2);

        // Zero load
        apply_stimulus(1'b1, 1'b0, 1'b0, 10'd0);
        step(1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 10'd0);
        check_output("zero_done_ms", int'(done_w[0]), 1);
        check_output("zero_done_us", int'(done_w[1]), 1);
        check_output("zero_busy", int'(busy_w[0]), 0);
        step(1);
        check_output("zero_done_drop", int'(done_w[0]), 0);
        check_output("zero_busy_after", int'(busy_w[0]), 0);
        step(2);

        // Pause for 7 cycles from RUN cycle 5
        apply_stimulus(1'b1, 1'b0, 1'b0, 10'd2);
        step(1);
        mark();
        apply_stimulus(1'b0, 1'b0, 1'b0, 10'd2);
        step(4);
        apply_stimulus(1'b0, 1'b0, 1'b1, 10'd2);
        step(7);
        check_output("pause_rem_frozen", int'(rem_w[0]), 2);
        check_output("pause_busy", int'(busy_w[0]), 1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 10'd2);
        step(20);
        check_output("pause_done_latency_ms", done_at[0], 27);
        check_output("pause_done_latency_us", done_at[1], 15);

        // Abort at RUN cycle 12
        apply_stimulus(1'b1, 1'b0, 1'b0, 10'd5);
        step(1);
        mark();
        apply_stimulus(1'b0, 1'b0, 1'b0, 10'd5);
        step(11);
        apply_stimulus(1'b0, 1'b1, 1'b0, 10'd5);
        step(1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 10'd5);
        check_output("abort_busy", int'(busy_w[0]), 0);
        check_output("abort_rem", int'(rem_w[0]), 0);
        check_output("abort_done", int'(done_w[0]), 0);
        step(60);
        check_output("abort_no_done_ms", done_at[0], -1);
        check_output("abort_no_done_us", done_at[1], -1);

        // Restart with a new load at RUN cycle 8
        apply_stimulus(1'b1, 1'b0, 1'b0, 10'd5);
        step(1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 10'd5);
        step(7);
        apply_stimulus(1'b1, 1'b0, 1'b0, 10'd4);
        step(1);
        mark();
        apply_stimulus(1'b0, 1'b0, 1'b0, 10'd4);
        check_output("restart_rem", int'(rem_w[0]), 4);
        check_output("restart_busy", int'(busy_w[0]), 1);
        step(45);
        check_output("restart_done_ms", done_at[0], 40);
        check_output("restart_done_us", done_at[1], 16);

        // Simultaneous abort and start
        apply_stimulus(1'b1, 1'b1, 1'b0, 10'd7);
        step(1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 10'd7);
        check_output("abort_start_busy", int'(busy_w[0]), 0);
        check_output("abort_start_rem", int'(rem_w[0]), 0);
        check_output("abort_start_done", int'(done_w[0]), 0);
        step(2);

        // Start while pause is held high
        apply_stimulus(1'b1, 1'b0, 1'b1, 10'd1);
        step(1);
        mark();
        apply_stimulus(1'b0, 1'b0, 1'b1, 10'd1);
        check_output("start_paused_busy", int'(busy_w[0]), 1);
        check_output("start_paused_rem", int'(rem_w[0]), 1);
        step(5);
        check_output("start_paused_hold", int'(rem_w[0]), 1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 10'd1);
        step(15);
        check_output("start_paused_done_ms", done_at[0], 15);
        check_output("start_paused_done_us", done_at[1], 9);

        // Async reset between edges during RUN
        apply_stimulus(1'b1, 1'b0, 1'b0, 10'd3);
        step(1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 10'd3);
        step(5);
        #1;
        reset_timer = 1'b1;
        #1;
        check_output("async_busy", int'(busy_w[0]), 0);
        check_output("async_rem", int'(rem_w[0]), 0);
        check_output("async_done", int'(done_w[0]), 0);
        check_output("async_busy_us", int'(busy_w[1]), 0);
        step(1);
        reset_timer = 1'b0;
        mark();
        step(50);
        check_output("async_no_done_ms", done_at[0], -1);
        check_output("async_no_done_us", done_at[1], -1);

        // Randomised traffic checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            apply_stimulus(($urandom_range(0, 39) == 0),
                           ($urandom_range(0, 99) == 0),
                           ($urandom_range(0, 5) == 0) ? ~pause : pause,
                           W'($urandom_range(0, 12)));
            step(1);
        end

        apply_stimulus(1'b0, 1'b0, 1'b0, '0);
        step(2);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
